extender_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate extender.
- Accepts immediate-generation requests over a valid/ready handshake. Produces zero-extend, sign-extend, upper-immediate, jump-target and branch-target words.
- Two register stages; sits between decode and the execute/PC-select logic.
- Supports backpressure, flush and reserved-mode error reporting.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/extender_pipe_if.sv | 36 +++
 rtl/extender_core.sv | 45 ++++
 rtl/extender_pipe.sv | 88 ++++++++
 tb/tb_extender_pipe.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: extender modes and default field widths.
// Imported by the extender core, its pipeline wrapper and handshake interface.
package cpu_types_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_IMM_W  = 16;
  localparam int DEF_ADDR_W = 26;
  localparam int EXT_MODE_W = 3;

  typedef enum logic [EXT_MODE_W-1:0] {
    ZERO   = 3'd0,
    SIGN   = 3'd1,
    UPPER  = 3'd2,
    JUMP   = 3'd3,
    BRANCH = 3'd4
  } ext_mode_t;

endpackage

// File: rtl/extender_pipe_if.sv
// Valid/ready request and result bundle for the pipelined extender.
// slave is the extender side, master is the decode/execute side.
interface extender_pipe_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [EXT_MODE_W-1:0] in_mode;
  logic [IMM_W-1:0]      in_imm16;
  logic [ADDR_W-1:0]     in_imm26;
  logic [WORD_W-1:0]     in_npc;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_W-1:0]     out_word;
  logic                  out_err;

  modport slave (
    input  in_valid, in_mode, in_imm16,
    input  in_imm26, in_npc, out_ready,
    output in_ready, out_valid,
    output out_word, out_err
  );

  modport master (
    output in_valid, in_mode, in_imm16,
    output in_imm26, in_npc, out_ready,
    input  in_ready, out_valid,
    input  out_word, out_err
  );

endinterface

// File: rtl/extender_core.sv
// Combinational immediate extender: mode + fields -> word + err.
// Shared by the pipelined wrapper and any single-cycle path.
module extender_core
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [EXT_MODE_W-1:0] mode,
  input  logic [IMM_W-1:0]      imm16,
  input  logic [ADDR_W-1:0]     imm26,
  input  logic [WORD_W-1:0]     npc,
  output logic [WORD_W-1:0]     word,
  output logic                  err
);

  localparam int PAD = WORD_W - IMM_W;
  localparam int JLO = ADDR_W + 2;

  logic [WORD_W-1:0] zext;
  logic [WORD_W-1:0] sext;
  logic [WORD_W-1:0] jfield;
  logic [WORD_W-1:0] jmask;

  assign zext   = {{PAD{1'b0}}, imm16};
  assign sext   = {{PAD{imm16[IMM_W-1]}}, imm16};
  assign jfield = WORD_W'({imm26, 2'b00});
  // Mask keeps the npc bits above the jump field; empty when the field fills the word.
  assign jmask  = ~((WORD_W'(1) << JLO) - WORD_W'(1));

  always_comb begin
    word = '0;
    err  = 1'b0;
    unique case (mode)
      ZERO:    word = zext;
      SIGN:    word = sext;
      UPPER:   word = {imm16, {PAD{1'b0}}};
      JUMP:    word = (npc & jmask) | jfield;
      BRANCH:  word = npc + (sext << 2);
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/extender_pipe.sv
// Two-stage pipelined immediate extender with valid/ready flow control,
// synchronous flush and reserved-mode error flag.
module extender_pipe
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  extender_pipe_if.slave  bus
);

  logic                  s1_valid;
  logic [EXT_MODE_W-1:0] s1_mode;
  logic [IMM_W-1:0]      s1_imm16;
  logic [ADDR_W-1:0]     s1_imm26;
  logic [WORD_W-1:0]     s1_npc;

  logic                  s2_valid;
  logic [WORD_W-1:0]     s2_word;
  logic                  s2_err;

  logic                  s2_adv;
  logic                  s1_adv;
  logic                  in_ready;
  logic                  accept;
  logic [WORD_W-1:0]     core_word;
  logic                  core_err;

  assign s2_adv   = !s2_valid || bus.out_ready;
  assign s1_adv   = s2_adv;
  assign in_ready = (!s1_valid || s1_adv) && !flush;
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_word  = s2_word;
  assign bus.out_err   = s2_err;

  extender_core #(
    .WORD_W (WORD_W),
    .IMM_W  (IMM_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .mode  (s1_mode),
    .imm16 (s1_imm16),
    .imm26 (s1_imm26),
    .npc   (s1_npc),
    .word  (core_word),
    .err   (core_err)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_imm16 <= '0;
      s1_imm26 <= '0;
      s1_npc   <= '0;
      s2_valid <= 1'b0;
      s2_word  <= '0;
      s2_err   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid;
      if (accept) begin
        s1_mode  <= bus.in_mode;
        s1_imm16 <= bus.in_imm16;
        s1_imm26 <= bus.in_imm26;
        s1_npc   <= bus.in_npc;
      end
      // Result registers only move when S2 is free, so a stalled word holds.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_word <= core_word;
          s2_err  <= core_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_extender_pipe.sv
// Bench for extender_pipe: directed vector table, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_extender_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  extender_pipe_if #() bus ();

  extender_pipe dut (
    .CLK   (clk),
    .RST   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] npc;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t tbl [12];
  logic [32:0] exp_q [$];
  logic        hold;
  logic [32:0] hold_val;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] n);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_imm16 = i16;
    bus.in_imm26 = i26;
    bus.in_npc   = n;
  endtask

  function automatic logic [32:0] model(input int unsigned m,
      input int unsigned i16, input int unsigned i26,
      input logic [31:0] n);
    int          simm;
    logic [31:0] w;
    simm = (i16 >= 32768) ? int'(i16) - 65536 : int'(i16);
    case (m)
      0: w = i16;
      1: w = simm;
      2: w = i16 * 65536;
      3: w = (n & 32'hF000_0000) | (i26 * 4);
      4: w = n + simm * 4;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, w};
  endfunction

  // One randomized cycle: drive at posedge+1, observe at negedge.
  task automatic rnd_cycle(input bit quiet);
    logic        fl;
    logic [32:0] got;
    logic [32:0] exp;
    step();
    fl = quiet ? 1'b0 : ($urandom_range(0, 31) == 0);
    flush         = fl;
    bus.in_valid  = quiet ? 1'b0 : 1'($urandom);
    bus.out_ready = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
    bus.in_mode   = 3'($urandom_range(0, 7));
    bus.in_imm16  = 16'($urandom);
    bus.in_imm26  = 26'($urandom);
    bus.in_npc    = $urandom;
    @(negedge clk);
    got = {bus.out_err, bus.out_word};
    if (hold) begin
      check("hold_valid", 64'(bus.out_valid), 64'(1));
      check("hold_data", 64'(got), 64'(hold_val));
    end
    if (bus.out_valid && bus.out_ready) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
      check("rnd_out", 64'(got), 64'(exp));
    end
    if (fl) begin
      check("flush_in_ready", 64'(bus.in_ready), 64'(0));
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_mode, bus.in_imm16,
                              bus.in_imm26, bus.in_npc));
      hold     = bus.out_valid && !bus.out_ready;
      hold_val = got;
    end
  endtask

  initial begin
    int          cnt;
    bit          acc3;
    logic [31:0] got [$];

    tbl[0]  = '{3'd1, 16'h8000, 26'h0, 32'h0, 32'hFFFF_8000, 1'b0};
    tbl[1]  = '{3'd0, 16'h8000, 26'h0, 32'h0, 32'h0000_8000, 1'b0};
    tbl[2]  = '{3'd4, 16'hFFFF, 26'h0, 32'h0000_0104, 32'h0000_0100, 1'b0};
    tbl[3]  = '{3'd4, 16'h0001, 26'h0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    tbl[4]  = '{3'd3, 16'h0, 26'h10, 32'h4000_0004, 32'h4000_0040, 1'b0};
    tbl[5]  = '{3'd2, 16'h1234, 26'h0, 32'h0, 32'h1234_0000, 1'b0};
    tbl[6]  = '{3'd6, 16'h1234, 26'h55, 32'h1, 32'h0, 1'b1};
    tbl[7]  = '{3'd5, 16'hFFFF, 26'h0, 32'h0, 32'h0, 1'b1};
    tbl[8]  = '{3'd7, 16'h0001, 26'h1, 32'h8, 32'h0, 1'b1};
    tbl[9]  = '{3'd1, 16'h7FFF, 26'h0, 32'h0, 32'h0000_7FFF, 1'b0};
    tbl[10] = '{3'd4, 16'h0010, 26'h0, 32'h0000_1000, 32'h0000_1040, 1'b0};
    tbl[11] = '{3'd3, 16'h0, 26'h3FF_FFFF, 32'hFFFF_FFF0,
                32'hFFFF_FFFC, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_mode   = '0;
    bus.in_imm16  = '0;
    bus.in_imm26  = '0;
    bus.in_npc    = '0;
    bus.out_ready = 1'b1;
    hold          = 1'b0;
    hold_val      = '0;

    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_word", 64'(bus.out_word), 64'(0));
    check("rst_out_err", 64'(bus.out_err), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    for (int i = 0; i < 12; i++) begin
      step();
      drive(tbl[i].mode, tbl[i].imm16, tbl[i].imm26, tbl[i].npc);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(1));
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_early", i), 64'(bus.out_valid), 64'(0));
      step();
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(1));
      check($sformatf("vec%0d_word", i), 64'(bus.out_word),
            64'(tbl[i].word));
      check($sformatf("vec%0d_err", i), 64'(bus.out_err), 64'(tbl[i].err));
    end

    // Back-to-back SIGN then ZERO.
    step();
    drive(3'd1, 16'h8000, 26'h0, 32'h0);
    step();
    drive(3'd0, 16'h8000, 26'h0, 32'h0);
    @(negedge clk);
    check("b2b_lat", 64'(bus.out_valid), 64'(0));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_first", 64'({bus.out_valid, bus.out_word}),
          64'({1'b1, 32'hFFFF_8000}));
    step();
    @(negedge clk);
    check("b2b_second", 64'({bus.out_valid, bus.out_word}),
          64'({1'b1, 32'h0000_8000}));
    step();
    @(negedge clk);
    check("b2b_drain", 64'(bus.out_valid), 64'(0));

    // Backpressure: third request must stall.
    step();
    bus.out_ready = 1'b0;
    drive(3'd0, 16'd1, 26'h0, 32'h0);
    @(negedge clk);
    check("bp_acc1", 64'(bus.in_ready), 64'(1));
    step();
    drive(3'd0, 16'd2, 26'h0, 32'h0);
    @(negedge clk);
    check("bp_acc2", 64'(bus.in_ready), 64'(1));
    step();
    drive(3'd0, 16'd3, 26'h0, 32'h0);
    @(negedge clk);
    check("bp_stall", 64'(bus.in_ready), 64'(0));
    check("bp_hold", 64'({bus.out_valid, bus.out_word}),
          64'({1'b1, 32'h1}));
    step();
    bus.out_ready = 1'b1;
    acc3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc3 = 1'b1;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_word);
      step();
      if (acc3) bus.in_valid = 1'b0;
    end
    check("bp_count", 64'(got.size()), 64'(3));
    for (int k = 0; k < 3; k++)
      check($sformatf("bp_order%0d", k),
            64'((got.size() > k) ? got[k] : 32'hFFFF_FFFF), 64'(k + 1));

    // Flush with both stages full and a new request pending.
    bus.out_ready = 1'b0;
    drive(3'd0, 16'hA, 26'h0, 32'h0);
    step();
    drive(3'd0, 16'hB, 26'h0, 32'h0);
    step();
    drive(3'd0, 16'hC, 26'h0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", 64'(bus.in_ready), 64'(0));
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("fl_out_valid", 64'(bus.out_valid), 64'(0));
    check("fl_ready_after", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("fl_no_output", 64'(cnt), 64'(0));

    // Asynchronous reset with both stages full.
    step();
    bus.out_ready = 1'b0;
    drive(3'd0, 16'h11, 26'h0, 32'h0);
    step();
    drive(3'd0, 16'h22, 26'h0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("ar_pre_valid", 64'(bus.out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("ar_async_drop", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("ar_no_stale", 64'(cnt), 64'(0));

    exp_q.delete();
    hold = 1'b0;
    for (int i = 0; i < 2000; i++) rnd_cycle(1'b0);
    for (int i = 0; i < 5; i++) rnd_cycle(1'b1);
    check("rnd_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
